mm_reg_arb: RTL and testbench
=============================

MM_REG_ARB -- requirements
Module: mm_reg_arb

Interface
REQ-001 Parameter ADDR_BITS, default 8, register address width of the shared peripheral port.
REQ-002 Parameter DATA_BITS, default 32, data width; SEL width is DATA_BITS/8.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles to wait for a slave ACK; counter width is clog2(TIMEOUT+1).
REQ-004 Clock and reset: clk, reset_n, asynchronous, active-low.
REQ-005 sync_reset  in  1  synchronous clear of all state, same effect as reset_n.
REQ-006 mN_rd_stb  in  1  read request from master N (N=0 core, N=1 debug); held high until mN_rd_ack.
REQ-007 mN_rd_adr  in  ADDR_BITS  read address from master N.
REQ-008 mN_rd_dat  out  DATA_BITS  read data to master N; valid only with mN_rd_ack.
REQ-009 mN_rd_ack  out  1  one-cycle read completion to master N.
REQ-010 mN_wr_stb, mN_wr_sel, mN_wr_adr, mN_wr_dat  in  1/SEL/ADDR_BITS/DATA_BITS  write request from master N; held until mN_wr_ack.
REQ-011 mN_wr_ack  out  1  one-cycle write completion to master N.
REQ-012 mN_err  out  1  pulses with the ack of any transaction that timed out.
REQ-013 s_rd_stb, s_rd_adr  out  1/ADDR_BITS  read strobe and address to the peripheral block.
REQ-014 s_rd_dat, s_rd_ack  in  DATA_BITS/1  read data and ack from the peripheral block.
REQ-015 s_wr_stb, s_wr_we, s_wr_sel, s_wr_adr, s_wr_dat  out  1/1/SEL/ADDR_BITS/DATA_BITS  write port to the peripheral block.
REQ-016 s_wr_ack  in  1  write ack from the peripheral block.

Function
REQ-017 Read and write channels SHALL be arbitrated by two independent, identical state machines; a read and a write SHALL proceed concurrently.
REQ-018 Channel states SHALL be IDLE, ISSUE, WAIT.
REQ-019 IDLE: with any mN_stb high, SHALL grant one master, register its address/sel/data, go to ISSUE.
REQ-020 Grant SHALL be round-robin: if both request, the master not granted last on that channel wins; last-grant pointer resets to 1 (master 0 wins first tie).
REQ-021 ISSUE: s_*_stb (and s_wr_we) SHALL be high exactly one cycle with registered fields; next state WAIT, timeout counter cleared.
REQ-022 WAIT: on s_*_ack, SHALL pulse the granted master's ack for one cycle (read data = s_rd_dat of that cycle), return to IDLE.
REQ-023 WAIT: if counter reaches TIMEOUT without ack, SHALL pulse granted master's ack and mN_err, read data 0, return to IDLE.
REQ-024 An ack arriving in IDLE or ISSUE SHALL be ignored.
REQ-025 Outputs to non-granted master SHALL stay 0; slave address/data outputs SHALL hold last value when idle.
REQ-026 Master released in IDLE the cycle after its ack SHALL not be re-granted on a stale strobe: a granted master's request is re-evaluated only from the cycle after its ack.
REQ-027 Minimum transaction latency: mN_stb rise to mN_ack = 3 cycles with a 1-cycle slave ack; back-to-back grants SHALL add no idle cycles beyond IDLE.

Reset
REQ-028 On reset_n low or sync_reset high: both channels IDLE, all strobes/acks/err 0, all data/address outputs 0, last-grant pointers 1, counters 0.
REQ-029 Reset mid-transaction SHALL abort it with no ack to the master.

Verification
REQ-030 m0 read adr 0x04, slave acks 1 cycle after s_rd_stb with 0x8000_0000 -> m0_rd_ack at cycle 3, m0_rd_dat 0x8000_0000, m1 outputs 0.
REQ-031 m0 and m1 write simultaneously, held -> m0 served first, then m1; next tie goes to m0 again only after m1 served.
REQ-032 Read by m1 and write by m0 same cycle -> s_rd_stb and s_wr_stb both asserted in same cycle, both acks returned.
REQ-033 m0 read, slave never acks, TIMEOUT=15 -> m0_rd_ack and m0_err pulse 16 cycles after ISSUE, m0_rd_dat 0.
REQ-034 reset_n low during WAIT -> no ack; after release, new m1 request completes normally.
REQ-035 Spurious s_wr_ack in IDLE -> no mN_wr_ack generated.

Source files
------------

// File: rtl/mm_reg_arb.sv
// Two-master arbiter in front of a single register-mapped peripheral.
// Reads and writes run on separate, identical channels, so a read and a write
// can be in flight at the same time.
//
// Handshake on every master port: the master raises stb with its fields and holds
// them unchanged until ack. ack (and err on timeout) is a one-cycle pulse, and read
// data is meaningful only in that cycle. A master's strobe is not looked at in its
// own ack cycle, so it has that cycle to drop the request. Toward the peripheral,
// s_*_stb is a one-cycle pulse. The peripheral answers with a one-cycle s_*_ack, and
// an ack that arrives while the channel is not waiting is ignored.

// One channel: round-robin grant, one-cycle issue, then wait for the ack or a timeout.
module mm_reg_arb_ch #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic [1:0] req,        // requests, already masked in the requester's ack cycle
  input  logic       s_ack,
  output logic       load,       // grant this cycle, so the caller captures the fields
  output logic       load_sel,   // which master is granted when load is high
  output logic       s_stb,
  output logic [1:0] done,       // completion for master N; the caller registers it
  output logic [1:0] fail,       // completion caused by a timeout
  output logic [1:0] state_dbg
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;

  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            lg_q, lg_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            s_stb_q, s_stb_d;

  // Next-state logic: grant in IDLE, pulse the strobe in ISSUE, wait for ack or timeout in WAIT.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    lg_d     = lg_q;
    cnt_d    = cnt_q;
    s_stb_d  = 1'b0;
    load     = 1'b0;
    load_sel = 1'b0;
    done     = 2'b00;
    fail     = 2'b00;
    cnt_inc  = cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          load     = 1'b1;
          // On a tie, the master that was not granted last wins.
          load_sel = (req == 2'b11) ? ~lg_q : req[1];
          gnt_d    = load_sel;
          lg_d     = load_sel;
          s_stb_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (s_ack) begin
          done[gnt_q] = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_inc == TO_LIMIT) begin
          done[gnt_q] = 1'b1;
          fail[gnt_q] = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (sync_reset) begin
      state_d = ST_IDLE;
      gnt_d   = 1'b0;
      lg_d    = 1'b1;
      cnt_d   = '0;
      s_stb_d = 1'b0;
      load    = 1'b0;
      done    = 2'b00;
      fail    = 2'b00;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      lg_q    <= 1'b1;
      cnt_q   <= '0;
      s_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
      s_stb_q <= s_stb_d;
    end
  end

  assign s_stb     = s_stb_q;
  assign state_dbg = state_q;
endmodule

// Top level: two channels plus the registered master and peripheral fields.
module mm_reg_arb #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   m0_rd_stb,
  input  logic [ADDR_BITS-1:0]   m0_rd_adr,
  output logic [DATA_BITS-1:0]   m0_rd_dat,
  output logic                   m0_rd_ack,
  input  logic                   m0_wr_stb,
  input  logic [DATA_BITS/8-1:0] m0_wr_sel,
  input  logic [ADDR_BITS-1:0]   m0_wr_adr,
  input  logic [DATA_BITS-1:0]   m0_wr_dat,
  output logic                   m0_wr_ack,
  output logic                   m0_err,
  input  logic                   m1_rd_stb,
  input  logic [ADDR_BITS-1:0]   m1_rd_adr,
  output logic [DATA_BITS-1:0]   m1_rd_dat,
  output logic                   m1_rd_ack,
  input  logic                   m1_wr_stb,
  input  logic [DATA_BITS/8-1:0] m1_wr_sel,
  input  logic [ADDR_BITS-1:0]   m1_wr_adr,
  input  logic [DATA_BITS-1:0]   m1_wr_dat,
  output logic                   m1_wr_ack,
  output logic                   m1_err,
  output logic                   s_rd_stb,
  output logic [ADDR_BITS-1:0]   s_rd_adr,
  input  logic [DATA_BITS-1:0]   s_rd_dat,
  input  logic                   s_rd_ack,
  output logic                   s_wr_stb,
  output logic                   s_wr_we,
  output logic [DATA_BITS/8-1:0] s_wr_sel,
  output logic [ADDR_BITS-1:0]   s_wr_adr,
  output logic [DATA_BITS-1:0]   s_wr_dat,
  input  logic                   s_wr_ack,
  output logic [1:0]             rd_state_dbg,
  output logic [1:0]             wr_state_dbg
);
  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int CW       = $clog2(TIMEOUT + 1);

  logic [1:0]           rd_req, wr_req, rd_done, wr_done, rd_fail, wr_fail;
  logic                 rd_load, rd_load_sel, wr_load, wr_load_sel;
  logic [1:0]           rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, err_q, err_d;
  logic [DATA_BITS-1:0] rd_dat0_q, rd_dat0_d, rd_dat1_q, rd_dat1_d;
  logic [ADDR_BITS-1:0] s_rd_adr_q, s_rd_adr_d, s_wr_adr_q, s_wr_adr_d;
  logic [SEL_BITS-1:0]  s_wr_sel_q, s_wr_sel_d;
  logic [DATA_BITS-1:0] s_wr_dat_q, s_wr_dat_d;

  // A master's strobe is still high in its own ack cycle, so it is masked there.
  assign rd_req = {m1_rd_stb & ~rd_ack_q[1], m0_rd_stb & ~rd_ack_q[0]};
  assign wr_req = {m1_wr_stb & ~wr_ack_q[1], m0_wr_stb & ~wr_ack_q[0]};

  mm_reg_arb_ch #(.TIMEOUT(TIMEOUT), .CW(CW)) u_rd_ch (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .req(rd_req), .s_ack(s_rd_ack),
    .load(rd_load), .load_sel(rd_load_sel), .s_stb(s_rd_stb), .done(rd_done),
    .fail(rd_fail), .state_dbg(rd_state_dbg)
  );

  mm_reg_arb_ch #(.TIMEOUT(TIMEOUT), .CW(CW)) u_wr_ch (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .req(wr_req), .s_ack(s_wr_ack),
    .load(wr_load), .load_sel(wr_load_sel), .s_stb(s_wr_stb), .done(wr_done),
    .fail(wr_fail), .state_dbg(wr_state_dbg)
  );

  // Register the master responses and capture the granted master's fields toward the peripheral.
  always_comb begin
    rd_ack_d   = rd_done;
    wr_ack_d   = wr_done;
    err_d      = rd_fail | wr_fail;
    rd_dat0_d  = (rd_done[0] & ~rd_fail[0]) ? s_rd_dat : '0;
    rd_dat1_d  = (rd_done[1] & ~rd_fail[1]) ? s_rd_dat : '0;
    s_rd_adr_d = s_rd_adr_q;
    s_wr_adr_d = s_wr_adr_q;
    s_wr_sel_d = s_wr_sel_q;
    s_wr_dat_d = s_wr_dat_q;
    if (rd_load) begin
      s_rd_adr_d = rd_load_sel ? m1_rd_adr : m0_rd_adr;
    end
    if (wr_load) begin
      s_wr_adr_d = wr_load_sel ? m1_wr_adr : m0_wr_adr;
      s_wr_sel_d = wr_load_sel ? m1_wr_sel : m0_wr_sel;
      s_wr_dat_d = wr_load_sel ? m1_wr_dat : m0_wr_dat;
    end
    if (sync_reset) begin
      rd_ack_d   = 2'b00;
      wr_ack_d   = 2'b00;
      err_d      = 2'b00;
      rd_dat0_d  = '0;
      rd_dat1_d  = '0;
      s_rd_adr_d = '0;
      s_wr_adr_d = '0;
      s_wr_sel_d = '0;
      s_wr_dat_d = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack_q   <= 2'b00;
      wr_ack_q   <= 2'b00;
      err_q      <= 2'b00;
      rd_dat0_q  <= '0;
      rd_dat1_q  <= '0;
      s_rd_adr_q <= '0;
      s_wr_adr_q <= '0;
      s_wr_sel_q <= '0;
      s_wr_dat_q <= '0;
    end else begin
      rd_ack_q   <= rd_ack_d;
      wr_ack_q   <= wr_ack_d;
      err_q      <= err_d;
      rd_dat0_q  <= rd_dat0_d;
      rd_dat1_q  <= rd_dat1_d;
      s_rd_adr_q <= s_rd_adr_d;
      s_wr_adr_q <= s_wr_adr_d;
      s_wr_sel_q <= s_wr_sel_d;
      s_wr_dat_q <= s_wr_dat_d;
    end
  end

  assign m0_rd_ack = rd_ack_q[0];
  assign m1_rd_ack = rd_ack_q[1];
  assign m0_wr_ack = wr_ack_q[0];
  assign m1_wr_ack = wr_ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rd_dat = rd_dat0_q;
  assign m1_rd_dat = rd_dat1_q;
  assign s_rd_adr  = s_rd_adr_q;
  assign s_wr_we   = s_wr_stb;
  assign s_wr_adr  = s_wr_adr_q;
  assign s_wr_sel  = s_wr_sel_q;
  assign s_wr_dat  = s_wr_dat_q;
endmodule

// File: tb/tb_mm_reg_arb.sv
// Bench for mm_reg_arb: directed steps, then a randomized mixed-traffic phase checked
// against a transaction-level model of the peripheral and the masters.
module tb_mm_reg_arb;
  localparam int AB = 8;
  localparam int DB = 32;
  localparam int SB = 4;
  localparam int TO = 15;
  localparam int NRND = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  always #5 clk = ~clk;

  // Requesters are indexed 0 = m0 read, 1 = m1 read, 2 = m0 write, 3 = m1 write.
  logic          rq_stb[4];
  logic [AB-1:0] rq_adr[4];
  logic [DB-1:0] rq_dat[4];
  logic [SB-1:0] rq_sel[4];

  logic [DB-1:0] m0_rd_dat, m1_rd_dat, s_rd_dat, s_wr_dat;
  logic          m0_rd_ack, m1_rd_ack, m0_wr_ack, m1_wr_ack, m0_err, m1_err;
  logic          s_rd_stb, s_rd_ack, s_wr_stb, s_wr_we, s_wr_ack;
  logic [AB-1:0] s_rd_adr, s_wr_adr;
  logic [SB-1:0] s_wr_sel;
  logic [1:0]    rd_state_dbg, wr_state_dbg;

  mm_reg_arb #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .m0_rd_stb(rq_stb[0]), .m0_rd_adr(rq_adr[0]), .m0_rd_dat(m0_rd_dat), .m0_rd_ack(m0_rd_ack),
    .m0_wr_stb(rq_stb[2]), .m0_wr_sel(rq_sel[2]), .m0_wr_adr(rq_adr[2]), .m0_wr_dat(rq_dat[2]),
    .m0_wr_ack(m0_wr_ack), .m0_err(m0_err),
    .m1_rd_stb(rq_stb[1]), .m1_rd_adr(rq_adr[1]), .m1_rd_dat(m1_rd_dat), .m1_rd_ack(m1_rd_ack),
    .m1_wr_stb(rq_stb[3]), .m1_wr_sel(rq_sel[3]), .m1_wr_adr(rq_adr[3]), .m1_wr_dat(rq_dat[3]),
    .m1_wr_ack(m1_wr_ack), .m1_err(m1_err),
    .s_rd_stb(s_rd_stb), .s_rd_adr(s_rd_adr), .s_rd_dat(s_rd_dat), .s_rd_ack(s_rd_ack),
    .s_wr_stb(s_wr_stb), .s_wr_we(s_wr_we), .s_wr_sel(s_wr_sel), .s_wr_adr(s_wr_adr),
    .s_wr_dat(s_wr_dat), .s_wr_ack(s_wr_ack),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // ---------------- peripheral model ----------------
  // A delay of 0 means never ack, -1 means a random 1..4, N means ack N cycles after the strobe.
  int          rd_dly = 1;
  int          wr_dly = 1;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic        rd_fixed_en = 1'b0;
  logic [DB-1:0] rd_fixed_val = '0;
  logic        spur_wr = 1'b0;
  logic [AB-1:0] rd_lat_adr = '0;
  logic [SB+AB+DB:0] wr_rec = '0;   // {we, sel, adr, dat} of the last write strobe seen

  function automatic logic [DB-1:0] rd_fn(input logic [AB-1:0] a);
    return {a ^ 8'hA5, a, ~a, a + 8'd3};
  endfunction

  initial begin
    s_rd_ack = 1'b0;
    s_wr_ack = 1'b0;
    s_rd_dat = '0;
    forever begin
      @(negedge clk);
      s_rd_ack = 1'b0;
      s_rd_dat = $urandom();           // junk unless acking
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          s_rd_ack = 1'b1;
          s_rd_dat = rd_fixed_en ? rd_fixed_val : rd_fn(rd_lat_adr);
        end
      end
      if (s_rd_stb && rd_dly != 0) begin
        rd_lat_adr = s_rd_adr;
        rd_cnt = (rd_dly < 0) ? int'($urandom_range(1, 4)) : rd_dly;
      end
      s_wr_ack = spur_wr;
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) s_wr_ack = 1'b1;
      end
      if (s_wr_stb) begin
        wr_rec = {s_wr_we, s_wr_sel, s_wr_adr, s_wr_dat};
        if (wr_dly != 0) wr_cnt = (wr_dly < 0) ? int'($urandom_range(1, 4)) : wr_dly;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(input int r);
    case (r)
      0: return m0_rd_ack;
      1: return m1_rd_ack;
      2: return m0_wr_ack;
      default: return m1_wr_ack;
    endcase
  endfunction

  function automatic logic get_err(input int r);
    return (r == 0 || r == 2) ? m0_err : m1_err;
  endfunction

  function automatic logic [DB-1:0] get_rdat(input int r);
    return (r == 0) ? m0_rd_dat : m1_rd_dat;
  endfunction

  function automatic logic [SB+AB+DB:0] wr_exp(input int r);
    return {1'b1, rq_sel[r], rq_adr[r], rq_dat[r]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input int r, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!get_ack(r) && n < limit);
  endtask

  // Both masters write and hold; returns the cycle of each ack counted from the request.
  task automatic wr_tie(input logic [AB-1:0] a0, input logic [AB-1:0] a1, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    rq_adr[2] = a0; rq_dat[2] = $urandom(); rq_sel[2] = 4'h3;
    rq_adr[3] = a1; rq_dat[3] = $urandom(); rq_sel[3] = 4'hC;
    rq_stb[2] = 1'b1;
    rq_stb[3] = 1'b1;
    for (int n = 1; n <= 30 && (c0 == 0 || c1 == 0); n++) begin
      tick();
      if (m0_wr_ack) begin
        c0 = n;
        chk("tie_rec_m0", wr_rec, wr_exp(2));
        rq_stb[2] = 1'b0;
      end
      if (m1_wr_ack) begin
        c1 = n;
        chk("tie_rec_m1", wr_rec, wr_exp(3));
        rq_stb[3] = 1'b0;
      end
    end
    rq_stb[2] = 1'b0;
    rq_stb[3] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, c0, c1, issue_n, seen;
    logic act[4];
    int started, finished;
    for (int r = 0; r < 4; r++) begin
      rq_stb[r] = 1'b0; rq_adr[r] = '0; rq_dat[r] = '0; rq_sel[r] = '0; act[r] = 1'b0;
    end

    // Reset state
    tick(); tick();
    chk("rst_ctl", {m0_rd_ack, m1_rd_ack, m0_wr_ack, m1_wr_ack, m0_err, m1_err, s_rd_stb, s_wr_stb, s_wr_we}, 0);
    chk("rst_rdat", {m0_rd_dat, m1_rd_dat}, 0);
    chk("rst_sadr", {s_rd_adr, s_wr_adr, s_wr_sel}, 0);
    chk("rst_sdat", s_wr_dat, 0);
    reset_n = 1'b1;
    tick(); tick();

    // Single m0 read with a one-cycle peripheral ack
    rd_fixed_en = 1'b1; rd_fixed_val = 32'h8000_0000; rd_dly = 1;
    rq_adr[0] = 8'h04; rq_stb[0] = 1'b1;
    wait_ack(0, 40, n);
    chk("rd_latency", n, 3);
    chk("rd_data", m0_rd_dat, 32'h8000_0000);
    chk("rd_err", m0_err, 0);
    chk("rd_m1_quiet", {m1_rd_ack, m1_wr_ack, m1_err, m1_rd_dat}, 0);
    rq_stb[0] = 1'b0;
    tick();
    chk("rd_ack_pulse", {m0_rd_ack, m0_rd_dat}, 0);
    chk("rd_adr_hold", s_rd_adr, 8'h04);
    rd_fixed_en = 1'b0;
    tick(); tick();

    // Two simultaneous writes, twice: m0 first each time, m1 back to back
    wr_dly = 1;
    wr_tie(8'h10, 8'h20, c0, c1);
    chk("tie1_m0", c0, 3);
    chk("tie1_m1", c1, 6);
    tick(); tick();
    wr_tie(8'h30, 8'h40, c0, c1);
    chk("tie2_m0", c0, 3);
    chk("tie2_m1", c1, 6);
    tick(); tick();

    // Concurrent m1 read and m0 write
    rq_adr[1] = 8'h33; rq_stb[1] = 1'b1;
    rq_adr[2] = 8'h44; rq_dat[2] = 32'hCAFE_F00D; rq_sel[2] = 4'hF; rq_stb[2] = 1'b1;
    tick();
    chk("conc_stb", {s_rd_stb, s_wr_stb, s_wr_we}, 3'b111);
    tick(); tick();
    chk("conc_acks", {m1_rd_ack, m0_wr_ack}, 2'b11);
    chk("conc_rdat", m1_rd_dat, rd_fn(8'h33));
    chk("conc_wrec", wr_rec, wr_exp(2));
    rq_stb[1] = 1'b0; rq_stb[2] = 1'b0;
    tick(); tick();

    // Read timeout: peripheral never acks
    rd_dly = 0;
    rq_adr[0] = 8'h55; rq_stb[0] = 1'b1;
    issue_n = 0;
    for (int i = 0; i < 10 && issue_n == 0; i++) begin
      tick();
      if (s_rd_stb) issue_n = i + 1;
    end
    chk("to_issue", issue_n, 1);
    wait_ack(0, 40, n);
    chk("to_latency", n, 16);
    chk("to_err", m0_err, 1);
    chk("to_rdat", m0_rd_dat, 0);
    rq_stb[0] = 1'b0;
    tick();
    chk("to_err_pulse", {m0_err, m0_rd_ack}, 0);
    tick(); tick();

    // Async reset during WAIT aborts silently, then m1 completes normally
    rq_adr[0] = 8'h5A; rq_stb[0] = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("ar_outs", {m0_rd_ack, m0_err, s_rd_stb, s_rd_adr}, 0);
    rq_stb[0] = 1'b0;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_rd_ack || m1_rd_ack || m0_err || m1_err) seen++;
    end
    chk("ar_no_ack", seen, 0);
    rd_dly = 2;
    rq_adr[1] = 8'h66; rq_stb[1] = 1'b1;
    wait_ack(1, 40, n);
    chk("ar_m1_latency", n, 4);
    chk("ar_m1_rdat", m1_rd_dat, rd_fn(8'h66));
    rq_stb[1] = 1'b0;
    tick(); tick();

    // Synchronous reset during a write WAIT
    wr_dly = 0;
    rq_adr[3] = 8'h77; rq_dat[3] = 32'h1234_5678; rq_sel[3] = 4'h5; rq_stb[3] = 1'b1;
    tick(); tick(); tick();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    rq_stb[3] = 1'b0;
    chk("sr_outs", {s_wr_stb, s_wr_adr, s_wr_sel, s_wr_dat}, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_wr_ack || m1_wr_ack || m0_err || m1_err) seen++;
    end
    chk("sr_no_ack", seen, 0);

    // Spurious write ack while idle
    spur_wr = 1'b1;
    tick();
    spur_wr = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_wr_ack || m1_wr_ack) seen++;
    end
    chk("spur_no_ack", seen, 0);

    // Random mixed traffic against the transaction model
    rd_dly = -1; wr_dly = -1;
    started = 0; finished = 0;
    for (int cyc = 0; cyc < 4000 && finished < NRND; cyc++) begin
      tick();
      for (int r = 0; r < 4; r++) begin
        if (act[r]) begin
          if (get_ack(r)) begin
            if (r < 2) begin
              chk("rnd_rdat", get_rdat(r), rd_fn(rq_adr[r]));
              chk("rnd_other_rdat", get_rdat(1 - r), 0);
            end else begin
              chk("rnd_wrec", wr_rec, wr_exp(r));
            end
            chk("rnd_err", get_err(r), 0);
            act[r] = 1'b0;
            rq_stb[r] = 1'b0;
            finished++;
          end
        end else if (started < NRND && $urandom_range(0, 3) == 0) begin
          rq_adr[r] = 8'($urandom());
          rq_dat[r] = $urandom();
          rq_sel[r] = 4'($urandom_range(1, 15));
          rq_stb[r] = 1'b1;
          act[r] = 1'b1;
          started++;
        end
      end
    end
    chk("rnd_all_done", finished, NRND);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
